// File: rtl/instr_seq_ctrl.sv
// Multi-cycle instruction sequencer: PC, instruction register, gated reg-file write strobe.
// Optional performance counters enabled by defining INSTR_SEQ_PERF_CNT_EN.
module instr_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1,
  parameter int          TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] last_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        ir_valid,
  input  logic        rf_we_req,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        busy,
  output logic        halted,
  output logic        error,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT, S_ERROR} state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_t      state, state_nxt;
  logic [7:0]  tcnt, tcnt_nxt;
  logic [31:0] pc_nxt, ir_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      ir    <= 32'h0;
      tcnt  <= 8'h0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
      tcnt  <= tcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    tcnt_nxt  = tcnt;
    case (state)
      S_IDLE: if (start) begin
        tcnt_nxt  = 8'h0;
        state_nxt = S_FETCH;
      end
      S_FETCH: if (imem_ack) begin
        ir_nxt    = imem_rdata;
        tcnt_nxt  = 8'h0;
        state_nxt = S_EXEC;
      end else begin
        // an ack in the cycle the limit is reached still wins (checked first)
        tcnt_nxt = tcnt + 8'd1;
        if (tcnt_nxt == TO_LIM) state_nxt = S_ERROR;
      end
      S_EXEC: if (pc == last_pc) begin
        state_nxt = S_HALT;
      end else begin
        pc_nxt    = pc + PC_STEP;
        state_nxt = S_FETCH;
      end
      S_HALT: if (start) begin
        pc_nxt    = RESET_PC;
        tcnt_nxt  = 8'h0;
        state_nxt = S_FETCH;
      end
      S_ERROR: state_nxt = S_ERROR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // decoded straight from state so reset drops imem_req without waiting for a clock
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign ir_valid  = (state == S_EXEC);
  assign rf_we     = ir_valid & rf_we_req;
  assign busy      = (state == S_FETCH) | (state == S_EXEC);
  assign halted    = (state == S_HALT);
  assign error     = (state == S_ERROR);

`ifdef INSTR_SEQ_PERF_CNT_EN
  logic restart;
  assign restart = halted & start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= 32'h0;
      instret_cnt <= 32'h0;
    end else if (restart) begin
      cycle_cnt   <= 32'h0;
      instret_cnt <= 32'h0;
    end else begin
      if (busy)     cycle_cnt   <= cycle_cnt + 32'd1;
      if (ir_valid) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`else
  assign cycle_cnt   = 32'h0;
  assign instret_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Scoreboard bench for instr_seq_ctrl: random wait-state memory, program model from RESET_PC to last_pc.
module tb_instr_seq_ctrl;
  localparam logic [31:0] RPC  = 32'h0;
  localparam logic [31:0] STEP = 32'd1;
  localparam int          TMO  = 15;

  logic        clk, rst_n, start, imem_req, imem_ack, ir_valid, rf_we_req, rf_we;
  logic        busy, halted, error;
  logic [31:0] last_pc, imem_addr, imem_rdata, ir, pc, cycle_cnt, instret_cnt;

  instr_seq_ctrl #(.RESET_PC(RPC), .PC_STEP(STEP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .last_pc(last_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .ir_valid(ir_valid), .rf_we_req(rf_we_req), .rf_we(rf_we), .pc(pc),
    .busy(busy), .halted(halted), .error(error),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic [31:0] data;} exp_t;
  exp_t expq[$];

  int checks = 0, errors = 0;
  bit resp_en = 0, mon_en = 0, stray = 0, have_ir = 0, prev_req = 0;
  int max_wait = 0, wcnt = 0, wtarget = 0, exp_cycles = 0;
  int busy_seen = 0, req_seen = 0, n_ret = 0, n_exp = 0;
  logic [31:0] prev_addr, last_ir;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // memory model: each fetch waits a random number of cycles, then acks with mem_word(addr)
  initial begin
    imem_ack = 0; imem_rdata = 0; rf_we_req = 0;
    forever begin
      @(negedge clk);
      rf_we_req  = 1'($urandom_range(0, 1));
      imem_ack   = stray;
      imem_rdata = $urandom;
      if (resp_en && imem_req === 1'b1) begin
        if (wcnt >= wtarget) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          exp_cycles += wtarget + 2;
          wcnt    = 0;
          wtarget = $urandom_range(0, max_wait);
        end else wcnt++;
      end
    end
  end

  // monitor: pops the scoreboard on every EXEC cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (mon_en) begin
        if (busy) busy_seen++;
        if (imem_req) begin
          req_seen++;
          if (expq.size() > 0) check32("fetch_addr", imem_addr, expq[0].addr);
        end
        if (ir_valid) begin
          if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_exec: got pc %h, expected no instruction", pc);
          end else begin
            e = expq.pop_front();
            check32("exec_pc", pc, e.addr);
            check32("ir", ir, e.data);
            last_ir = e.data; have_ir = 1; n_ret++;
          end
          check32("rf_we_exec", 32'(rf_we), 32'(rf_we_req));
        end else begin
          check32("rf_we_gated", 32'(rf_we), 32'h0);
          if (have_ir) check32("ir_hold", ir, last_ir);
        end
        if (imem_req && prev_req) check32("addr_stable", imem_addr, prev_addr);
        prev_req = imem_req; prev_addr = imem_addr;
      end
    end
  end

  task automatic start_run(input logic [31:0] lp, input int mw);
    logic [31:0] a;
    @(negedge clk);
    last_pc = lp; max_wait = mw; wcnt = 0; wtarget = $urandom_range(0, mw);
    exp_cycles = 0; busy_seen = 0; req_seen = 0; n_ret = 0; n_exp = 0;
    a = RPC;
    for (int k = 0; k < 64; k++) begin
      expq.push_back('{a, mem_word(a)});
      n_exp++;
      if (a == lp) break;
      a = a + STEP;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input logic [31:0] lp, input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      @(negedge clk); #3;
      if (halted) break;
    end
    check32("halt_reached", 32'(halted), 32'h1);
    check32("halt_pc", pc, lp);
    check32("busy_cycles", 32'(busy_seen), 32'(exp_cycles));
    check32("instr_count", 32'(n_ret), 32'(n_exp));
    check32("queue_empty", 32'(expq.size()), 32'h0);
`ifdef INSTR_SEQ_PERF_CNT_EN
    check32("cycle_cnt", cycle_cnt, 32'(exp_cycles));
    check32("instret_cnt", instret_cnt, 32'(n_exp));
`else
    check32("cycle_cnt_tied", cycle_cnt, 32'h0);
    check32("instret_cnt_tied", instret_cnt, 32'h0);
`endif
  endtask

  task automatic apply_reset();
    mon_en = 0; resp_en = 0;
    #1 rst_n = 1'b0;
    #1;
    check32("rst_req", 32'(imem_req), 32'h0);
    check32("rst_pc", pc, RPC);
    check32("rst_ir", ir, 32'h0);
    check32("rst_flags", {26'h0, ir_valid, rf_we, busy, halted, error, imem_req}, 32'h0);
    check32("rst_cnt", cycle_cnt | instret_cnt, 32'h0);
    expq.delete(); have_ir = 0; prev_req = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int i;
    logic [31:0] lp;
    int mw;
    rst_n = 1'b1; start = 1'b0; last_pc = 0;
    #2;
    apply_reset();

    // zero-wait run to 3, then restart from HALT with wait states
    mon_en = 1; resp_en = 1;
    start_run(32'd3, 0);
    wait_halt(32'd3, 40);
    start_run(32'd1, 0);
    wait_halt(32'd1, 40);
    for (int r = 0; r < 8; r++) begin
      lp = 32'($urandom_range(0, 6));
      mw = $urandom_range(0, 4);
      start_run(lp, mw);
      wait_halt(lp, (int'(lp) + 1) * (mw + 2) + 10);
    end

    // fetch timeout: memory never acks
    resp_en = 0;
    start_run(32'd5, 0);
    for (i = 0; i < 100; i++) begin
      @(negedge clk); #3;
      if (error) break;
    end
    check32("timeout_error", 32'(error), 32'h1);
    check32("timeout_req_cycles", 32'(req_seen), 32'(TMO));
    check32("error_req_low", 32'(imem_req), 32'h0);
    expq.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check32("error_sticky", {30'h0, error, busy}, 32'h2);
    apply_reset();
    check32("error_cleared", 32'(error), 32'h0);

    // async reset mid-fetch at pc=2, then stray acks in IDLE
    mon_en = 1; resp_en = 1;
    start_run(32'd5, 3);
    for (i = 0; i < 100; i++) begin
      @(negedge clk); #3;
      if (imem_req && pc == 32'd2) break;
    end
    check32("reached_pc2_fetch", {31'h0, imem_req}, 32'h1);
    apply_reset();
    stray = 1;
    repeat (3) begin
      @(negedge clk); #3;
      check32("stray_ack_idle", {28'h0, busy, ir_valid, halted, imem_req}, 32'h0);
      check32("stray_ack_pc", pc, RPC);
    end
    stray = 0;

    // normal operation again after the reset
    mon_en = 1; resp_en = 1;
    start_run(32'd2, 2);
    wait_halt(32'd2, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end
endmodule
